dct_quantizer: RTL and testbench
================================

DCT_QUANTIZER -- requirements
Module: dct_quantizer

Interface
REQ-001 SHALL have parameter LANES, default 8, coefficients per row word.
REQ-002 SHALL have parameter CW, default 10, signed DCT coefficient width.
REQ-003 SHALL have parameter QW, default 8, signed quantized output width.
REQ-004 SHALL have port clk  input  1  single clock; all logic rising-edge.
REQ-005 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-006 SHALL have port in_data  input  LANES*CW (80)  one DCT row; lane k = bits [k*CW +: CW], column k.
REQ-007 SHALL have port in_valid  input  1  in_data valid.
REQ-008 SHALL have port in_ready  output  1  block accepts in_data this cycle.
REQ-009 SHALL have port chroma  input  1  table select (0 luma, 1 chroma); sampled only on row-0 acceptance.
REQ-010 SHALL have port out_data  output  LANES*QW (64)  quantized row, same lane order.
REQ-011 SHALL have port out_valid  output  1  out_data valid.
REQ-012 SHALL have port out_ready  input  1  consumer accepts out_data.
REQ-013 SHALL have port out_last  output  1  high with out_valid on row 7 of a block.

Function
REQ-014 SHALL transfer input when in_valid && in_ready, and output when out_valid && out_ready.
REQ-015 SHALL be a 2-stage pipeline (S1 multiply, S2 round/saturate); latency 2 cycles from input transfer to out_valid with out_ready held high.
REQ-016 SHALL advance all stages when S2 empty or out_ready; in_ready = that advance condition; no data lost or duplicated under any out_ready pattern.
REQ-017 SHALL sustain one row per cycle while in_valid and out_ready are both high.
REQ-018 SHALL keep a 3-bit row counter, incremented per input transfer, wrapping 7->0; row r selects quant table row r.
REQ-019 SHALL latch chroma on row-0 transfer and use it for rows 0-7 of that block.
REQ-020 SHALL compute per lane p = coeff * recip, recip = round(65536/Q), 17-bit unsigned, from the packaged table.
REQ-021 SHALL produce q = sign(p) * ((|p| + 32768) >> 16) (round half away from zero) when rounding is compiled in.
REQ-022 SHALL saturate q to [-128, 127].
REQ-023 SHALL carry row-7 flag alongside data so out_last aligns with its row.
REQ-024 SHALL hold out_data/out_last stable while out_valid && !out_ready.

Reset
REQ-025 SHALL on reset clear all pipeline valids, row counter to 0, latched chroma to 0.
REQ-026 SHALL drive out_valid=0, out_data=0, out_last=0, in_ready=1 in the cycle after reset is sampled high.
REQ-027 SHALL discard any partial block on reset mid-operation; next accepted row is row 0.

Configuration
REQ-028 SHALL honour macro DCT_QUANT_ROUND_EN: defined -> rounding per REQ-021; undefined -> truncation toward zero, q = sign(p) * (|p| >> 16).

Structure
REQ-029 SHALL take LANES, CW, QW, standard JPEG luma/chroma quant tables and their 17-bit reciprocal tables from shared package jpeg_pkg.
REQ-030 SHALL instantiate LANES copies of sub-module quant_lane (one coefficient multiply/round/saturate).

Verification
REQ-031 SHALL check: row 0 luma, lane 0 = 100 (Q=16) -> out lane 0 = 6 after 2 cycles.
REQ-032 SHALL check: row 0 luma, lane 0 = -40 -> -3 with DCT_QUANT_ROUND_EN, -2 without.
REQ-033 SHALL check: 16 back-to-back rows, out_ready=1 -> 16 outputs consecutive, out_last on outputs 8 and 16, row counter wraps.
REQ-034 SHALL check: out_ready held 0 for 5 cycles mid-stream -> in_ready low after pipeline fills, out_data stable, no row lost after release.
REQ-035 SHALL check: chroma=1 at row 0, toggled at rows 1-7 -> all 8 rows use chroma table (row 0 lane 0, coeff 170, Q=17 -> 10).
REQ-036 SHALL check: reset asserted after row 3 -> out_valid=0 next cycle; following block's first row uses table row 0.

Source files
------------

// File: rtl/jpeg_pkg.sv
// jpeg_pkg: shared widths, standard JPEG luma/chroma quant tables (row-major,
// index = row*8 + column) and their 17-bit round(65536/Q) reciprocal tables.
package jpeg_pkg;
  localparam int JPEG_LANES = 8;
  localparam int JPEG_CW = 10;
  localparam int JPEG_QW = 8;
  typedef logic [0:63][7:0] qtab_t;
  typedef logic [0:63][16:0] rtab_t;
  localparam qtab_t LUMA_Q = '{
    8'd16, 8'd11, 8'd10, 8'd16, 8'd24, 8'd40, 8'd51, 8'd61,
    8'd12, 8'd12, 8'd14, 8'd19, 8'd26, 8'd58, 8'd60, 8'd55,
    8'd14, 8'd13, 8'd16, 8'd24, 8'd40, 8'd57, 8'd69, 8'd56,
    8'd14, 8'd17, 8'd22, 8'd29, 8'd51, 8'd87, 8'd80, 8'd62,
    8'd18, 8'd22, 8'd37, 8'd56, 8'd68, 8'd109, 8'd103, 8'd77,
    8'd24, 8'd35, 8'd55, 8'd64, 8'd81, 8'd104, 8'd113, 8'd92,
    8'd49, 8'd64, 8'd78, 8'd87, 8'd103, 8'd121, 8'd120, 8'd101,
    8'd72, 8'd92, 8'd95, 8'd98, 8'd112, 8'd100, 8'd103, 8'd99};
  localparam qtab_t CHROMA_Q = '{
    8'd17, 8'd18, 8'd24, 8'd47, 8'd99, 8'd99, 8'd99, 8'd99,
    8'd18, 8'd21, 8'd26, 8'd66, 8'd99, 8'd99, 8'd99, 8'd99,
    8'd24, 8'd26, 8'd56, 8'd99, 8'd99, 8'd99, 8'd99, 8'd99,
    8'd47, 8'd66, 8'd99, 8'd99, 8'd99, 8'd99, 8'd99, 8'd99,
    8'd99, 8'd99, 8'd99, 8'd99, 8'd99, 8'd99, 8'd99, 8'd99,
    8'd99, 8'd99, 8'd99, 8'd99, 8'd99, 8'd99, 8'd99, 8'd99,
    8'd99, 8'd99, 8'd99, 8'd99, 8'd99, 8'd99, 8'd99, 8'd99,
    8'd99, 8'd99, 8'd99, 8'd99, 8'd99, 8'd99, 8'd99, 8'd99};
  function automatic rtab_t mk_recip(input qtab_t t);
    rtab_t r;
    for (int i = 0; i < 64; i++) r[i] = (17'd65536 + 17'(t[i] >> 1)) / 17'(t[i]);
    return r;
  endfunction
  localparam rtab_t LUMA_RECIP = mk_recip(LUMA_Q);
  localparam rtab_t CHROMA_RECIP = mk_recip(CHROMA_Q);
endpackage

// File: rtl/quant_lane.sv
// quant_lane: one coefficient; S1 multiplies by reciprocal, S2 rounds/truncates
// and saturates. DCT_QUANT_ROUND_EN selects round-half-away-from-zero.
module quant_lane #(
  parameter int CW = 10,
  parameter int QW = 8
)(
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 en,
  input  logic signed [CW-1:0] coeff,
  input  logic [16:0]          recip,
  output logic [QW-1:0]        q
);
  localparam int PW = CW + 18;
  localparam int MW = PW - 16;
  localparam logic [MW-1:0] POS_LIM = MW'(2 ** (QW - 1) - 1);
  localparam logic [MW-1:0] NEG_LIM = MW'(2 ** (QW - 1));
  localparam logic [QW-1:0] QMAX = {1'b0, {(QW - 1){1'b1}}};
  localparam logic [QW-1:0] QMIN = {1'b1, {(QW - 1){1'b0}}};
  logic signed [PW-1:0] ce, re, p_d, p_q;
  logic [PW-1:0] mag;
  logic [MW-1:0] qm;
  logic [QW-1:0] q_d, q_q;
  always_comb begin
    ce = PW'(coeff);
    re = PW'($signed({1'b0, recip}));
    p_d = ce * re;
    mag = p_q[PW-1] ? -p_q : p_q;
`ifdef DCT_QUANT_ROUND_EN
    qm = MW'((mag + PW'(32768)) >> 16);
`else
    qm = MW'(mag >> 16);
`endif
    q_d = p_q[PW-1] ? (qm > NEG_LIM ? QMIN : QW'(-qm)) : (qm > POS_LIM ? QMAX : QW'(qm));
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      p_q <= '0;
      q_q <= '0;
    end else if (en) begin
      p_q <= p_d;
      q_q <= q_d;
    end
  end
  assign q = q_q;
endmodule

// File: rtl/dct_quantizer.sv
// dct_quantizer: 2-stage JPEG quantizer, one 8-lane DCT row per cycle with
// backpressure. Rounding mode set by macro DCT_QUANT_ROUND_EN (else truncation).
module dct_quantizer import jpeg_pkg::*; #(
  parameter int LANES = JPEG_LANES,
  parameter int CW = JPEG_CW,
  parameter int QW = JPEG_QW
)(
  input  logic                  clk,
  input  logic                  reset,
  input  logic [LANES*CW-1:0]   in_data,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic                  chroma,
  output logic [LANES*QW-1:0]   out_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  out_last
);
  logic [2:0] row_q, row_d;
  logic chroma_q, chroma_d, v1_q, v2_q, l1_q, l2_q, adv, acc, sel;
  assign adv = !v2_q || out_ready;
  assign acc = in_valid && adv;
  // row 0 uses the live chroma input; the rest of the block uses the latched copy
  assign sel = (row_q == 3'd0) ? chroma : chroma_q;
  always_comb begin
    row_d = acc ? row_q + 3'd1 : row_q;
    chroma_d = (acc && row_q == 3'd0) ? chroma : chroma_q;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      row_q <= '0;
      chroma_q <= 1'b0;
      v1_q <= 1'b0;
      v2_q <= 1'b0;
      l1_q <= 1'b0;
      l2_q <= 1'b0;
    end else begin
      row_q <= row_d;
      chroma_q <= chroma_d;
      if (adv) begin
        v1_q <= in_valid;
        l1_q <= in_valid && row_q == 3'd7;
        v2_q <= v1_q;
        l2_q <= l1_q;
      end
    end
  end
  for (genvar k = 0; k < LANES; k++) begin : g_lane
    logic [16:0] recip;
    assign recip = sel ? CHROMA_RECIP[{row_q, 3'(k)}] : LUMA_RECIP[{row_q, 3'(k)}];
    quant_lane #(.CW(CW), .QW(QW)) u_lane (
      .clk   (clk),
      .reset (reset),
      .en    (adv),
      .coeff (in_data[k*CW +: CW]),
      .recip (recip),
      .q     (out_data[k*QW +: QW])
    );
  end
  assign in_ready = adv;
  assign out_valid = v2_q;
  assign out_last = l2_q;
endmodule

// File: tb/tb_dct_quantizer.sv
// tb_dct_quantizer: scoreboard bench for dct_quantizer; honours DCT_QUANT_ROUND_EN.
module tb_dct_quantizer;
  import jpeg_pkg::*;
  logic clk = 1'b0, reset = 1'b1, in_valid = 1'b0, chroma = 1'b0, out_ready = 1'b1;
  logic in_ready, out_valid, out_last;
  logic [79:0] in_data = '0;
  logic [63:0] out_data, snap;
  typedef struct packed {logic [63:0] d; logic l;} exp_t;
  exp_t sbq[$];
  int total = 0, bad = 0, m_row = 0, run = 0, run_max = 0, n;
  bit m_ch = 1'b0, prev = 1'b0;
`ifdef DCT_QUANT_ROUND_EN
  localparam int EXP_M40 = -3;
  localparam int EXP_C170 = 10;
`else
  localparam int EXP_M40 = -2;
  localparam int EXP_C170 = 9;
`endif

  dct_quantizer dut (
    .clk(clk), .reset(reset), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .chroma(chroma), .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .out_last(out_last)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] model(input logic [79:0] d, input int r, input bit ch);
    logic [63:0] res;
    longint c, p, mag, q;
    int qv, rc;
    res = '0;
    for (int k = 0; k < 8; k++) begin
      c = longint'($signed(d[k*10 +: 10]));
      qv = ch ? int'(CHROMA_Q[r*8+k]) : int'(LUMA_Q[r*8+k]);
      rc = $rtoi(65536.0 / qv + 0.5);
      p = c * rc;
      mag = p < 0 ? -p : p;
`ifdef DCT_QUANT_ROUND_EN
      mag = (mag + 32768) / 65536;
`else
      mag = mag / 65536;
`endif
      q = p < 0 ? -mag : mag;
      if (q > 127) q = 127;
      if (q < -128) q = -128;
      res[k*8 +: 8] = q[7:0];
    end
    return res;
  endfunction

  function automatic logic [79:0] rnd_row();
    logic [79:0] d;
    for (int k = 0; k < 8; k++) d[k*10 +: 10] = 10'($urandom_range(0, 1023));
    return d;
  endfunction

  function automatic logic [79:0] row_with(input int c0);
    logic [79:0] d;
    d = rnd_row();
    d[9:0] = 10'(c0);
    return d;
  endfunction

  always @(negedge clk) begin
    exp_t e;
    if (out_valid && out_ready) begin
      run = prev ? run + 1 : 1;
      prev = 1'b1;
      if (run > run_max) run_max = run;
      if (sbq.size() == 0) chk("extra_out", 1, 0);
      else begin
        e = sbq.pop_front();
        chk("row_data", out_data, e.d);
        chk("row_last", 64'(out_last), 64'(e.l));
      end
    end else prev = 1'b0;
  end

  // called just after a rising edge; returns just after the edge that took the row
  task automatic send(input logic [79:0] d, input bit ch, output int waits);
    in_data = d;
    chroma = ch;
    in_valid = 1'b1;
    waits = 0;
    do begin
      @(negedge clk);
      waits++;
    end while (!in_ready && waits < 50);
    if (!in_ready) chk("accept_timeout", 0, 1);
    else begin
      if (m_row == 0) m_ch = ch;
      sbq.push_back('{model(d, m_row, m_ch), m_row == 7});
      m_row = (m_row + 1) % 8;
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int w = 0;
    while (sbq.size() > 0 && w < 200) begin
      @(negedge clk);
      w++;
    end
    chk("drain", 64'(sbq.size()), 0);
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    @(posedge clk);
    #1;
    chk("rst_out_valid", 64'(out_valid), 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_out_last", 64'(out_last), 0);
    chk("rst_in_ready", 64'(in_ready), 1);
    reset = 1'b0;
    sbq.delete();
    m_row = 0;
    m_ch = 1'b0;
  endtask

  task automatic lat_check(input string tag, input int exp);
    chk({tag, "_early"}, 64'(out_valid), 0);
    @(posedge clk);
    #1;
    chk({tag, "_valid"}, 64'(out_valid), 1);
    chk({tag, "_lane0"}, 64'($signed(out_data[7:0])), 64'(exp));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    @(posedge clk);
    #1;
    do_reset();
    send(row_with(100), 1'b0, n);
    lat_check("luma100", 6);
    drain();
    do_reset();
    send(row_with(-40), 1'b0, n);
    lat_check("luma_m40", EXP_M40);
    drain();
    // 17 back-to-back rows: out_last on 8th and 16th, 17th wraps to table row 0
    do_reset();
    run_max = 0;
    for (int i = 0; i < 17; i++) begin
      send(rnd_row(), 1'b0, n);
      chk("b2b_wait", 64'(n), 1);
    end
    drain();
    chk("b2b_run", 64'(run_max), 17);
    do_reset();
    send(rnd_row(), 1'b0, n);
    send(rnd_row(), 1'b0, n);
    out_ready = 1'b0;
    snap = out_data;
    fork
      send(rnd_row(), 1'b0, n);
      begin
        repeat (5) begin
          @(negedge clk);
          chk("stall_in_ready", 64'(in_ready), 0);
          chk("stall_out_valid", 64'(out_valid), 1);
          chk("stall_hold", out_data, snap);
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
      end
    join
    send(rnd_row(), 1'b0, n);
    drain();
    do_reset();
    send(row_with(170), 1'b1, n);
    lat_check("chroma170", EXP_C170);
    for (int r = 1; r < 8; r++) send(rnd_row(), r % 2 == 0, n);
    drain();
    do_reset();
    for (int r = 0; r < 4; r++) send(rnd_row(), 1'b0, n);
    do_reset();
    send(row_with(500), 1'b0, n);
    lat_check("post_rst_row0", 31);
    drain();
    do_reset();
    fork
      for (int i = 0; i < 24; i++) send(rnd_row(), 1'($urandom_range(0, 1)), n);
      begin
        repeat (60) begin
          @(posedge clk);
          #1;
          out_ready = 1'($urandom_range(0, 1));
        end
        out_ready = 1'b1;
      end
    join
    out_ready = 1'b1;
    drain();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
